// File: rtl/gate_truth_table_tester.sv
// gate_truth_table_tester: sweeps a/b through all vectors and checks x=NAND, y=NOR, reporting via start/done.
module gate_truth_table_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             x,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       fail_vec
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, NEXT, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] vec, vec_n;
  logic [PW-1:0] sweep;
  logic [SW-1:0] cnt;
  logic last, mis;
  assign vec_n = vec + 2'd1;
  assign last = vec == 2'd3 && sweep == PW'(PASSES - 1);
  assign mis = (x != ~(a & b)) || (y != ~(a | b));
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? APPLY : IDLE;
      APPLY:   state_nx = SETTLE_CYCLES == 0 ? SAMPLE : SETTLE;
      SETTLE:  state_nx = cnt == '0 ? SAMPLE : SETTLE;
      SAMPLE:  state_nx = NEXT;
      NEXT:    state_nx = last ? DONE : APPLY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // a/b are loaded with the upcoming vector on the edge entering APPLY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= 1'b0;
      b <= 1'b0;
      vec <= '0;
      sweep <= '0;
      cnt <= '0;
      pass <= 1'b0;
      err_count <= '0;
      fail_vec <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a <= 1'b0;
          b <= 1'b0;
          vec <= '0;
          sweep <= '0;
          pass <= 1'b0;
          err_count <= '0;
          fail_vec <= '0;
        end
        APPLY: cnt <= SW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
        SETTLE: cnt <= cnt - 1'b1;
        SAMPLE: if (mis) begin
          if (~&err_count) err_count <= err_count + 1'b1;
          fail_vec[vec] <= 1'b1;
        end
        NEXT: if (last) pass <= err_count == '0;
        else begin
          vec <= vec_n;
          if (vec == 2'd3) sweep <= sweep + 1'b1;
          a <= vec_n[1];
          b <= vec_n[0];
        end
        DONE: begin
          a <= 1'b0;
          b <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_truth_table_tester.sv
// tb_gate_truth_table_tester: randomized fault-injection runs on two tester configurations with a done-driven scoreboard.
module tb_gate_truth_table_tester;
  typedef struct {
    int err;
    logic [3:0] fv;
    logic pass;
    int cyc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [3:0] xf0 = '0, yf0 = '0, xf1 = '0, yf1 = '0;
  logic a0, b0, x0, y0, busy0, done0, pass0, a1, b1, x1, y1, busy1, done1, pass1;
  logic [7:0] err_count0;
  logic [1:0] err_count1;
  logic [3:0] fail_vec0, fail_vec1;
  int tests = 0, fails = 0, cyc = 0, t0 = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // gates under test with per-vector output flips as the injected faults
  assign x0 = ~(a0 & b0) ^ xf0[{a0, b0}];
  assign y0 = ~(a0 | b0) ^ yf0[{a0, b0}];
  assign x1 = ~(a1 & b1) ^ xf1[{a1, b1}];
  assign y1 = ~(a1 | b1) ^ yf1[{a1, b1}];
  gate_truth_table_tester u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .x(x0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0), .fail_vec(fail_vec0)
  );
  gate_truth_table_tester #(.SETTLE_CYCLES(0), .PASSES(5), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .x(x1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1), .fail_vec(fail_vec1)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] xf, input logic [3:0] yf, input int passes,
                                 input int cntw, input int settle, input int k);
    exp_t e;
    int n;
    int mx;
    n = $countones(xf | yf) * passes;
    mx = (1 << cntw) - 1;
    e.fv = xf | yf;
    e.err = n > mx ? mx : n;
    e.pass = n == 0;
    e.cyc = k + 1 + 4 * passes * (settle + 3);
    return e;
  endfunction
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) chk("u0_spurious_done", {31'd0, done0}, 0);
      else begin
        e0 = q0.pop_front();
        chk("u0_err_count", {24'd0, err_count0}, e0.err);
        chk("u0_fail_vec", {28'd0, fail_vec0}, {28'd0, e0.fv});
        chk("u0_pass", {31'd0, pass0}, {31'd0, e0.pass});
        chk("u0_done_cycle", cyc, e0.cyc);
      end
    end
    if (busy0 && !done0) begin
      chk("u0_ab", {30'd0, a0, b0}, (t0 / 5) % 4);
      t0++;
    end else t0 = 0;
    if (done1) begin
      if (q1.size() == 0) chk("u1_spurious_done", {31'd0, done1}, 0);
      else begin
        e1 = q1.pop_front();
        chk("u1_err_count", {30'd0, err_count1}, e1.err);
        chk("u1_fail_vec", {28'd0, fail_vec1}, {28'd0, e1.fv});
        chk("u1_pass", {31'd0, pass1}, {31'd0, e1.pass});
        chk("u1_done_cycle", cyc, e1.cyc);
      end
    end
  end
  task automatic run(input int id, input logic [3:0] xf, input logic [3:0] yf, input bit repulse);
    logic d;
    @(negedge clk);
    if (id == 0) begin
      xf0 = xf; yf0 = yf;
      q0.push_back(model(xf, yf, 1, 8, 2, cyc));
      start0 = 1'b1;
    end else begin
      xf1 = xf; yf1 = yf;
      q1.push_back(model(xf, yf, 5, 2, 0, cyc));
      start1 = 1'b1;
    end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    if (repulse) begin
      repeat (6) @(negedge clk);
      if (id == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
    end
    d = id == 0 ? done0 : done1;
    for (int i = 0; i < 400 && !d; i++) begin
      @(negedge clk);
      d = id == 0 ? done0 : done1;
    end
    if (!d) chk("done_timeout", {31'd0, d}, 1);
    @(negedge clk);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("u0_reset", {15'd0, a0, b0, busy0, done0, pass0, err_count0, fail_vec0}, 0);
    chk("u1_reset", {21'd0, a1, b1, busy1, done1, pass1, err_count1, fail_vec1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(0, 4'b0000, 4'b0000, 0);
    run(0, 4'b1000, 4'b0000, 0);
    run(0, 4'b0110, 4'b0110, 0);
    run(0, 4'b0000, 4'b0000, 1);
    run(1, 4'b1000, 4'b0000, 0);
    run(1, 4'b0000, 4'b0000, 1);
    for (int i = 0; i < 6; i++) run(0, 4'($urandom), 4'($urandom), 0);
    for (int i = 0; i < 3; i++) run(1, 4'($urandom), 4'($urandom), 0);
    // abort a run during SETTLE of vector 2 with one error already logged
    @(negedge clk);
    xf0 = 4'b0001; yf0 = 4'b0000; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_reset_state", {29'd0, a0, b0, busy0}, {29'd0, 3'b101});
    chk("pre_reset_err", {24'd0, err_count0}, 1);
    #1 rst_n = 1'b0;
    #1 chk("mid_run_reset", {15'd0, a0, b0, busy0, done0, pass0, err_count0, fail_vec0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 4'b0000, 4'b0000, 0);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
